// File: rtl/pea_enable_sched.sv
// Firing-enable scheduler for a three-phase polynomial-evaluation actor.
// Optional stall counter on OUTPUT back-pressure: define PEA_ENABLE_STALL_CNT_EN.
module pea_enable_sched #(
    parameter int WORD_SIZE   = 16,
    parameter int BUFFER_SIZE = 1024,
    parameter int STALL_W     = 16,
    localparam int CW = (BUFFER_SIZE <= 1) ? 1 : $clog2(BUFFER_SIZE)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [CW-1:0]      command_pop,
    input  logic [CW-1:0]      data_pop,
    input  logic [CW-1:0]      result_free_space,
    input  logic [CW-1:0]      status_free_space,
    input  logic [2:0]         mode,
    input  logic [4:0]         b,
    input  logic [3:0]         N,
    input  logic               fire,
    input  logic               done,
    output logic               enable,
    output logic [1:0]         phase,
`ifdef PEA_ENABLE_STALL_CNT_EN
    output logic               busy,
    output logic               fire_err,
    output logic [STALL_W-1:0] stall_count
`else
    output logic               busy,
    output logic               fire_err
`endif
);

    localparam int CMP_W = (CW > 5) ? CW : 5;
    localparam logic [CMP_W-1:0] ONE_C = {{(CMP_W-1){1'b0}}, 1'b1};

    localparam logic [2:0] MODE_GET_COMMAND = 3'd0;
    localparam logic [2:0] MODE_STP         = 3'd1;
    localparam logic [2:0] MODE_EVP         = 3'd2;
    localparam logic [2:0] MODE_EVB         = 3'd3;
    localparam logic [2:0] MODE_RST         = 3'd4;

    typedef enum logic [1:0] {
        PH_SETUP_COMP = 2'd0,
        PH_COMP       = 2'd1,
        PH_OUTPUT     = 2'd2
    } phase_t;

    if (WORD_SIZE < 1 || STALL_W < 1) begin : g_param_check
        $error("pea_enable_sched: WORD_SIZE and STALL_W must be positive");
    end

    phase_t      phase_r, phase_nxt_s;
    logic        busy_r;
    logic        enable_r;
    logic        fire_err_r;
    logic        rst_dly_r;
    logic [2:0]  held_mode_r;
    logic [4:0]  held_b_r;
    logic [3:0]  held_n_r;

    logic             ready_s;
    logic             fire_acc_s;
    logic             done_acc_s;
    logic             enable_nxt_s;
    logic [CMP_W-1:0] cmd_x_s, data_x_s, result_x_s, status_x_s;
    logic [CMP_W-1:0] b_x_s, np1_x_s, r_x_s;

    // Zero-extend every comparison operand to a common width.
    always_comb begin
        cmd_x_s    = CMP_W'(command_pop);
        data_x_s   = CMP_W'(data_pop);
        result_x_s = CMP_W'(result_free_space);
        status_x_s = CMP_W'(status_free_space);
        b_x_s      = CMP_W'(b);
        np1_x_s    = CMP_W'({1'b0, N} + 5'd1);
        if (held_mode_r == MODE_EVB) begin
            r_x_s = CMP_W'(held_b_r);
        end else begin
            r_x_s = ONE_C;
        end
    end

    // Readiness term for the current phase; OUTPUT uses the values latched at fire.
    always_comb begin
        ready_s = 1'b0;
        case (phase_r)
            PH_SETUP_COMP: begin
                case (mode)
                    MODE_GET_COMMAND: ready_s = (cmd_x_s >= ONE_C);
                    MODE_STP:         ready_s = (data_x_s >= np1_x_s);
                    MODE_EVP:         ready_s = (data_x_s >= ONE_C);
                    MODE_EVB:         ready_s = (b != 5'd0) && (data_x_s >= b_x_s);
                    MODE_RST:         ready_s = 1'b1;
                    default:          ready_s = 1'b0;
                endcase
            end
            PH_COMP:   ready_s = ~busy_r;
            PH_OUTPUT: ready_s = (status_x_s >= ONE_C) && (result_x_s >= r_x_s);
            default:   ready_s = 1'b0;
        endcase
    end

    // Handshake qualification; a done in the same cycle always wins over fire.
    always_comb begin
        done_acc_s   = done & busy_r;
        fire_acc_s   = fire & enable_r & ~busy_r & ~done;
        enable_nxt_s = ready_s & ~busy_r & ~fire_acc_s & ~done_acc_s & ~rst_dly_r;
    end

    // Phase next-state decode.
    always_comb begin
        phase_nxt_s = phase_r;
        if (done_acc_s) begin
            case (phase_r)
                PH_COMP: begin
                    if (held_mode_r == MODE_EVP || held_mode_r == MODE_EVB) begin
                        phase_nxt_s = PH_OUTPUT;
                    end else begin
                        phase_nxt_s = PH_SETUP_COMP;
                    end
                end
                PH_OUTPUT: phase_nxt_s = PH_SETUP_COMP;
                default:   phase_nxt_s = phase_r;
            endcase
        end else if (fire_acc_s && phase_r == PH_SETUP_COMP) begin
            phase_nxt_s = PH_COMP;
        end else begin
            phase_nxt_s = phase_r;
        end
    end

    // Phase, handshake and latched-command state.
    always_ff @(posedge clk) begin
        if (rst) begin
            phase_r     <= PH_SETUP_COMP;
            busy_r      <= 1'b0;
            enable_r    <= 1'b0;
            fire_err_r  <= 1'b0;
            rst_dly_r   <= 1'b1;
            held_mode_r <= 3'd0;
            held_b_r    <= 5'd0;
            held_n_r    <= 4'd0;
        end else begin
            phase_r   <= phase_nxt_s;
            enable_r  <= enable_nxt_s;
            rst_dly_r <= 1'b0;
            if (fire_acc_s) begin
                busy_r <= 1'b1;
            end else if (done_acc_s) begin
                busy_r <= 1'b0;
            end
            if (fire && !fire_acc_s) begin
                fire_err_r <= 1'b1;
            end
            // A new invocation starts only from SETUP_COMP; OUTPUT reuses the held command.
            if (fire_acc_s && phase_r == PH_SETUP_COMP) begin
                held_mode_r <= mode;
                held_b_r    <= b;
                held_n_r    <= N;
            end
        end
    end

`ifdef PEA_ENABLE_STALL_CNT_EN
    logic [STALL_W-1:0] stall_cnt_r;

    // Saturating count of idle OUTPUT cycles spent waiting on downstream space.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_r <= {STALL_W{1'b0}};
        end else if (phase_r == PH_OUTPUT && !busy_r && !ready_s && !(&stall_cnt_r)) begin
            stall_cnt_r <= stall_cnt_r + {{(STALL_W-1){1'b0}}, 1'b1};
        end
    end

    assign stall_count = stall_cnt_r;
`endif

    assign enable   = enable_r;
    assign phase    = phase_r;
    assign busy     = busy_r;
    assign fire_err = fire_err_r;

    logic unused_s;
    assign unused_s = ^held_n_r;

endmodule

// File: tb/tb_pea_enable_sched.sv
// Directed self-checking bench for pea_enable_sched (default 1024-deep FIFOs).
module tb_pea_enable_sched;

    logic       clk = 1'b0;
    logic       rst;
    logic [9:0] command_pop, data_pop, result_free_space, status_free_space;
    logic [2:0] mode;
    logic [4:0] b;
    logic [3:0] N;
    logic       fire, done;
    logic       enable;
    logic [1:0] phase;
    logic       busy, fire_err;
`ifdef PEA_ENABLE_STALL_CNT_EN
    logic [15:0] stall_count;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pea_enable_sched dut (
        .clk(clk), .rst(rst),
        .command_pop(command_pop), .data_pop(data_pop),
        .result_free_space(result_free_space), .status_free_space(status_free_space),
        .mode(mode), .b(b), .N(N), .fire(fire), .done(done),
        .enable(enable), .phase(phase),
`ifdef PEA_ENABLE_STALL_CNT_EN
        .busy(busy), .fire_err(fire_err), .stall_count(stall_count)
`else
        .busy(busy), .fire_err(fire_err)
`endif
    );

    typedef struct packed {
        logic [2:0] mode;
        logic [4:0] b;
        logic [3:0] n;
        logic [9:0] cmd;
        logic [9:0] data;
        logic       exp_en;
    } vec_t;

    vec_t vecs[16];

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic pulse_fire();
        fire = 1'b1; step(1); fire = 1'b0;
    endtask

    task automatic pulse_done();
        done = 1'b1; step(1); done = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1; step(1); rst = 1'b0;
    endtask

    initial begin
        vecs[0]  = '{3'd0, 5'd0,  4'd0,  10'd0, 10'd0,    1'b0};
        vecs[1]  = '{3'd0, 5'd0,  4'd0,  10'd1, 10'd0,    1'b1};
        vecs[2]  = '{3'd1, 5'd0,  4'd3,  10'd0, 10'd3,    1'b0};
        vecs[3]  = '{3'd1, 5'd0,  4'd3,  10'd0, 10'd4,    1'b1};
        vecs[4]  = '{3'd1, 5'd0,  4'd15, 10'd0, 10'd15,   1'b0};
        vecs[5]  = '{3'd1, 5'd0,  4'd15, 10'd0, 10'd16,   1'b1};
        vecs[6]  = '{3'd2, 5'd0,  4'd0,  10'd0, 10'd0,    1'b0};
        vecs[7]  = '{3'd2, 5'd0,  4'd0,  10'd0, 10'd1,    1'b1};
        vecs[8]  = '{3'd3, 5'd5,  4'd0,  10'd0, 10'd4,    1'b0};
        vecs[9]  = '{3'd3, 5'd5,  4'd0,  10'd0, 10'd5,    1'b1};
        vecs[10] = '{3'd3, 5'd0,  4'd0,  10'd0, 10'd1023, 1'b0};
        vecs[11] = '{3'd3, 5'd31, 4'd0,  10'd0, 10'd31,   1'b1};
        vecs[12] = '{3'd4, 5'd0,  4'd0,  10'd0, 10'd0,    1'b1};
        vecs[13] = '{3'd5, 5'd1,  4'd0,  10'd5, 10'd5,    1'b0};
        vecs[14] = '{3'd7, 5'd1,  4'd0,  10'd5, 10'd5,    1'b0};
        vecs[15] = '{3'd3, 5'd31, 4'd0,  10'd0, 10'd30,   1'b0};

        rst = 1'b1; fire = 1'b0; done = 1'b0;
        command_pop = 10'd0; data_pop = 10'd0;
        result_free_space = 10'd0; status_free_space = 10'd0;
        mode = 3'd0; b = 5'd0; N = 4'd0;
        step(2);
        check("rst_enable", 32'(enable), 32'd0);
        check("rst_phase", 32'(phase), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_fire_err", 32'(fire_err), 32'd0);
`ifdef PEA_ENABLE_STALL_CNT_EN
        check("rst_stall", 32'(stall_count), 32'd0);
`endif
        rst = 1'b0;

        // SETUP_COMP readiness per mode
        for (int i = 0; i < 16; i++) begin
            mode = vecs[i].mode; b = vecs[i].b; N = vecs[i].n;
            command_pop = vecs[i].cmd; data_pop = vecs[i].data;
            step(2);
            check($sformatf("vec%0d_enable", i), 32'(enable), 32'(vecs[i].exp_en));
        end

        // STP: one-cycle registered response to data_pop
        mode = 3'd1; N = 4'd3; data_pop = 10'd3;
        step(3);
        check("stp_low", 32'(enable), 32'd0);
        data_pop = 10'd4;
        step(1);
        check("stp_rise", 32'(enable), 32'd1);

        // done while idle is ignored
        pulse_done();
        check("idle_done_phase", 32'(phase), 32'd0);

        // EVB full invocation through OUTPUT
        mode = 3'd3; b = 5'd5; data_pop = 10'd5;
        result_free_space = 10'd4; status_free_space = 10'd1;
        step(2);
        check("evb_en", 32'(enable), 32'd1);
        pulse_fire();
        check("evb_fire_phase", 32'(phase), 32'd1);
        check("evb_fire_busy", 32'(busy), 32'd1);
        check("evb_fire_en", 32'(enable), 32'd0);
        step(2);
        check("evb_busy_en", 32'(enable), 32'd0);
        pulse_done();
        check("evb_out_phase", 32'(phase), 32'd2);
        check("evb_out_busy", 32'(busy), 32'd0);
        check("evb_out_en0", 32'(enable), 32'd0);
        step(1);
        check("evb_out_res4", 32'(enable), 32'd0);
        result_free_space = 10'd5;
        step(1);
        check("evb_out_res5", 32'(enable), 32'd1);
        pulse_fire();
        check("evb_out_fire_busy", 32'(busy), 32'd1);
        check("evb_out_fire_phase", 32'(phase), 32'd2);
        pulse_done();
        check("evb_back_phase", 32'(phase), 32'd0);
        check("evb_back_busy", 32'(busy), 32'd0);

        // EVB with b=0 never enables
        b = 5'd0; data_pop = 10'd1023;
        for (int i = 0; i < 20; i++) begin
            step(1);
            check($sformatf("evb_b0_cyc%0d", i), 32'(enable), 32'd0);
        end

        // fire while enable=0
        pulse_fire();
        check("bad_fire_phase", 32'(phase), 32'd0);
        check("bad_fire_busy", 32'(busy), 32'd0);
        check("bad_fire_err", 32'(fire_err), 32'd1);
        mode = 3'd4;
        step(5);
        check("fire_err_sticky", 32'(fire_err), 32'd1);
        do_reset();
        check("fire_err_cleared", 32'(fire_err), 32'd0);

        // rst mid-invocation, then enable only from the second edge
        mode = 3'd0; command_pop = 10'd1;
        step(2);
        pulse_fire();
        check("gc_busy", 32'(busy), 32'd1);
        rst = 1'b1; done = 1'b1; step(1); rst = 1'b0; done = 1'b0;
        check("mid_rst_phase", 32'(phase), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_en", 32'(enable), 32'd0);
        step(1);
        check("post_rst_edge1", 32'(enable), 32'd0);
        step(1);
        check("post_rst_edge2", 32'(enable), 32'd1);

        // fire and done together: done wins, fire rejected
        pulse_fire();
        fire = 1'b1; done = 1'b1; step(1); fire = 1'b0; done = 1'b0;
        check("fd_phase", 32'(phase), 32'd0);
        check("fd_busy", 32'(busy), 32'd0);
        check("fd_fire_err", 32'(fire_err), 32'd1);

`ifdef PEA_ENABLE_STALL_CNT_EN
        do_reset();
        mode = 3'd2; data_pop = 10'd1; status_free_space = 10'd0; result_free_space = 10'd0;
        step(2);
        pulse_fire();
        pulse_done();
        check("stall_out_phase", 32'(phase), 32'd2);
        step(3);
        check("stall_small", 32'(stall_count), 32'd3);
        repeat (70000) @(posedge clk);
        #1;
        check("stall_sat", 32'(stall_count), 32'hFFFF);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pea_enable_sched.md
PEA_ENABLE_SCHED -- requirements
Module: pea_enable_sched

Interface
REQ-001 Parameter: WORD_SIZE, default 16, data token width in bits; informational only, no port depends on it.
REQ-002 Parameter: BUFFER_SIZE, default 1024, FIFO depth; CW = log2(BUFFER_SIZE), with log2(1) = 1.
REQ-003 Parameter: STALL_W, default 16, stall counter width.
REQ-004 clk  input  1  sole clock; all state updates on the rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 command_pop  input  CW  command FIFO population.
REQ-007 data_pop  input  CW  data FIFO population.
REQ-008 result_free_space  input  CW  result FIFO free words.
REQ-009 status_free_space  input  CW  status FIFO free words.
REQ-010 mode  input  3  decoded mode: GET_COMMAND=0, STP=1, EVP=2, EVB=3, RST=4; values 5-7 are invalid.
REQ-011 b  input  5  second command argument.
REQ-012 N  input  4  degree of the selected coefficient vector.
REQ-013 fire  input  1  one-cycle pulse from the actor: the invocation starts.
REQ-014 done  input  1  one-cycle pulse from the actor: the current phase's work is complete.
REQ-015 enable  output  1  registered firing permission.
REQ-016 phase  output  2  current phase: SETUP_COMP=0, COMP=1, OUTPUT=2.
REQ-017 busy  output  1  high from an accepted fire until the matching done.
REQ-018 fire_err  output  1  sticky flag: fire was received while enable=0.
REQ-019 stall_count  output  STALL_W  stall counter; present only with the macro (REQ-037).

Function
REQ-020 Phase FSM transitions:
- SETUP_COMP -> COMP on an accepted fire.
- COMP -> OUTPUT on done when mode is EVP or EVB.
- COMP -> SETUP_COMP on done for every other mode.
- OUTPUT -> SETUP_COMP on done.
REQ-021 Readiness in SETUP_COMP, by mode:
- GET_COMMAND: command_pop >= 1.
- STP: data_pop >= N+1, with N+1 computed in 5 bits.
- EVP: data_pop >= 1.
- EVB: data_pop >= b, and b != 0.
- RST: always ready.
- Invalid mode: never ready.
REQ-022 Readiness in COMP: ready whenever busy=0.
REQ-023 Readiness in OUTPUT: needs status_free_space >= 1 and result_free_space >= R, where R = b for EVB and R = 1 for EVP.
REQ-024 All comparisons are unsigned, with operands zero-extended to max(CW, 5) bits.
REQ-025 enable is the readiness term registered one cycle, with no combinational path to the output.
REQ-026 enable is forced 0 while busy=1, and in the cycle after any accepted fire or done.
REQ-027 A fire is accepted only when enable=1 and busy=0; acceptance sets busy=1 on the next edge.
REQ-028 A fire received while enable=0 is ignored and sets fire_err; fire_err clears only on rst.
REQ-029 done clears busy on the next edge and advances the phase per REQ-020.
REQ-030 done received while busy=0 is ignored, and the phase is unchanged.
REQ-031 When fire and done arrive in the same cycle, done is processed first and fire is treated as not accepted (it sets fire_err per REQ-028).
REQ-032 mode, b and N are sampled at fire acceptance and held internally until the next SETUP_COMP; OUTPUT readiness and the REQ-020 branch use the held values.

Reset
REQ-033 When rst is sampled high, on that edge: phase=SETUP_COMP, enable=0, busy=0, fire_err=0, stall_count=0, and held mode/b/N are cleared to 0.
REQ-034 rst overrides fire and done in the same cycle.
REQ-035 rst mid-invocation (busy=1 or phase=OUTPUT) abandons the invocation; no done is required afterwards.
REQ-036 The first enable can assert no earlier than the second edge after rst deasserts.

Configuration
REQ-037 Macro PEA_ENABLE_STALL_CNT_EN, when defined:
- stall_count increments on each cycle with phase=OUTPUT, busy=0 and readiness false.
- It saturates at all-ones.
- It clears on rst only.
REQ-038 Without the macro, the stall_count port and its logic are absent; all other behaviour is identical.

Verification
REQ-039 Scenario: mode=STP, N=3, data_pop=3 -> enable stays 0; data_pop raised to 4 -> enable=1 one cycle later.
REQ-040 Scenario: mode=EVB, b=5, data_pop=5, fire, done -> phase goes to OUTPUT; with result_free_space=4, enable=0; result_free_space raised to 5 -> enable=1; fire, done -> phase returns to SETUP_COMP.
REQ-041 Scenario: mode=EVB, b=0, data_pop=1023 -> enable stays 0 for 20 cycles.
REQ-042 Scenario: fire pulsed while enable=0 -> phase unchanged and fire_err=1; fire_err held until rst.
REQ-043 Scenario: rst asserted while busy=1 in COMP -> next cycle phase=0, busy=0, enable=0; with command_pop=1 and mode=GET_COMMAND, enable=1 on the second edge after rst deasserts.
REQ-044 Scenario, macro on: OUTPUT phase, status_free_space=0 held for 70000 cycles -> stall_count=16'hFFFF (saturated).
